fft_out_stage: RTL and testbench

Parametrised, flow-controlled successor to the FFT core's registered output stage. It accepts one LANES-wide beat of butterfly results per cycle and applies an optional final conditional modular subtraction and an optional bit-reversed lane permutation. Results are buffered in a small FIFO behind a valid/ready handshake, and the stage marks frame boundaries for the memory write-back path. It sits between the FFT datapath outputs and the mem_IN write ports.

---
 rtl/fft_out_pkg.sv | 39 +++
 rtl/fft_out_if.sv | 39 +++
 rtl/fft_out_fifo.sv | 70 +++++++
 rtl/fft_out_stage.sv | 159 +++++++++++++++
 tb/tb_fft_out_stage.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_out_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_out_pkg                                                                |
// | Shared types, constants and helpers for the FFT output stage.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package fft_out_pkg;

  localparam int c_DATA_WIDTH    = `DATA_WIDTH;
  localparam int c_DEFAULT_LANES = 8;
  localparam int c_LOG2_LANES    = $clog2(c_DEFAULT_LANES);

  typedef logic [c_DATA_WIDTH-1:0] lane_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  // Reverses the low nbits of idx; used to build the lane permutation network.
  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned nbits);
    int unsigned r;
    int unsigned v;
    r = 32'd0;
    v = idx;
    for (int unsigned b = 0; b < nbits; b++) begin
      r = (r << 1) | (v & 32'd1);
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_out_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_out_if                                                                 |
// | Input/output beat streams of the FFT output stage with per-beat controls. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

interface fft_out_if
  import fft_out_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int LANES      = c_DEFAULT_LANES
);

  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DATA_WIDTH-1:0] in_data;
  logic [DATA_WIDTH-1:0]       modular;
  logic                        reduce_en;
  logic                        perm_en;

  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*DATA_WIDTH-1:0] out_data;
  logic                        out_last;

  modport master (
    output in_valid, in_data, modular, reduce_en, perm_en, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, modular, reduce_en, perm_en, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

`default_nettype wire

// File: rtl/fft_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_out_fifo                                                               |
// | First-word fall-through FIFO with occupancy count, async active-high rst. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module fft_out_fifo
  import fft_out_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  wire                     clk,
  input  wire                     rst_n,
  input  wire                     wr_en,
  input  wire [WIDTH-1:0]         wr_data,
  input  wire                     rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int c_PTR_W = $clog2(DEPTH);

  if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
    $error("fft_out_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_do_rd;
  logic w_do_wr;

  assign w_full  = (r_count == (c_PTR_W+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_do_rd = rd_en && !w_empty;
  // A write into a full FIFO is only legal when a read frees the slot this edge.
  assign w_do_wr = wr_en && (!w_full || w_do_rd);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      if (w_do_wr && !w_do_rd)      r_count <= r_count + (c_PTR_W+1)'(1);
      else if (!w_do_wr && w_do_rd) r_count <= r_count - (c_PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  // Storage is not reset, so the head is masked while empty.
  assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
  assign empty   = w_empty;
  assign count   = r_count;

endmodule

`default_nettype wire

// File: rtl/fft_out_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_out_stage                                                              |
// | Reduce / bit-reverse permute pipeline with credit-based output FIFO and   |
// | frame-boundary marking for the memory write-back path.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module fft_out_stage
  import fft_out_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int LANES      = c_DEFAULT_LANES,
  parameter int FIFO_DEPTH = 4
) (
  input  wire         clk,
  input  wire         rst_n,
  fft_out_if.slave    bus,
  input  wire [15:0]  frame_beats,
  input  wire         err_clr,
  output logic        range_err
);

  localparam int c_W       = LANES * DATA_WIDTH;
  localparam int c_LOG2_LN = $clog2(LANES);
  localparam int c_CNT_W   = $clog2(FIFO_DEPTH) + 1;

  if (!is_pow2(LANES) || (LANES < 2) || (LANES > 16)) begin : g_bad_lanes
    $error("fft_out_stage: LANES must be a power of two in 2..16");
  end
  if (!is_pow2(FIFO_DEPTH) || (FIFO_DEPTH < 2)) begin : g_bad_depth
    $error("fft_out_stage: FIFO_DEPTH must be a power of two >= 2");
  end

  logic               w_in_ready;
  logic               w_accept;
  logic [c_W-1:0]     w_p1_next;
  logic [LANES-1:0]   w_ge_2q;
  logic               w_range_hit;

  logic               r_p1_valid;
  logic [c_W-1:0]     r_p1_data;
  logic               r_p1_perm;

  logic [c_W-1:0]     w_perm;
  logic [c_W-1:0]     w_p2_next;
  logic               r_p2_valid;
  logic [c_W-1:0]     r_p2_data;

  logic [c_W-1:0]     w_fifo_data;
  logic               w_fifo_empty;
  logic [c_CNT_W-1:0] w_fifo_count;
  logic [c_CNT_W:0]   w_used;

  logic               w_out_valid;
  logic               w_out_fire;
  logic               w_at_last;
  logic [15:0]        w_last_idx;
  logic [15:0]        r_beat_cnt;

  assign w_accept = bus.in_valid && w_in_ready;

  // P1: conditional subtraction plus a 2q range check in one extra bit.
  for (genvar i = 0; i < LANES; i++) begin : g_reduce
    logic [DATA_WIDTH-1:0] w_x;
    logic                  w_ge_q;
    assign w_x        = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_ge_q     = (w_x >= bus.modular);
    assign w_ge_2q[i] = ({1'b0, w_x} >= {bus.modular, 1'b0});
    assign w_p1_next[i*DATA_WIDTH +: DATA_WIDTH] =
      (bus.reduce_en && w_ge_q) ? (w_x - bus.modular) : w_x;
  end

  assign w_range_hit = w_accept && bus.reduce_en && (|w_ge_2q);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_p1_valid <= 1'b0;
      r_p1_data  <= '0;
      r_p1_perm  <= 1'b0;
    end else begin
      r_p1_valid <= w_accept;
      if (w_accept) begin
        r_p1_data <= w_p1_next;
        r_p1_perm <= bus.perm_en;
      end
    end
  end

  // P2: fixed bit-reversal wiring, selected per beat.
  for (genvar i = 0; i < LANES; i++) begin : g_perm
    localparam int unsigned c_SRC = bitrev(i, c_LOG2_LN);
    assign w_perm[i*DATA_WIDTH +: DATA_WIDTH] = r_p1_data[c_SRC*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_p2_next = r_p1_perm ? w_perm : r_p1_data;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_p2_valid <= 1'b0;
      r_p2_data  <= '0;
    end else begin
      r_p2_valid <= r_p1_valid;
      r_p2_data  <= w_p2_next;
    end
  end

  fft_out_fifo #(
    .WIDTH (c_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (r_p2_valid),
    .wr_data (r_p2_data),
    .rd_en   (bus.out_ready),
    .rd_data (w_fifo_data),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

  // Credits cover buffered plus in-flight beats, so the pipeline never stalls.
  assign w_used = {1'b0, w_fifo_count}
                + {{c_CNT_W{1'b0}}, r_p1_valid}
                + {{c_CNT_W{1'b0}}, r_p2_valid};
  assign w_in_ready = !rst_n && (w_used < (c_CNT_W+1)'(FIFO_DEPTH));

  assign w_out_valid = !w_fifo_empty;
  assign w_out_fire  = w_out_valid && bus.out_ready;
  assign w_last_idx  = (frame_beats == 16'd0) ? 16'd0 : (frame_beats - 16'd1);
  assign w_at_last   = (r_beat_cnt == w_last_idx);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_beat_cnt <= '0;
    end else if (w_out_fire) begin
      r_beat_cnt <= w_at_last ? 16'd0 : (r_beat_cnt + 16'd1);
    end
  end

  // A new violation wins over a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      range_err <= 1'b0;
    end else if (w_range_hit) begin
      range_err <= 1'b1;
    end else if (err_clr) begin
      range_err <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_fifo_data;
  assign bus.out_last  = w_out_valid && w_at_last;

endmodule

`default_nettype wire

// File: tb/tb_fft_out_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fft_out_stage                                                           |
// | Directed and randomized checks of fft_out_stage against a beat-level model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module tb_fft_out_stage;
  import fft_out_pkg::*;

  localparam int DW    = c_DATA_WIDTH;
  localparam int LN    = 8;
  localparam int DEPTH = 4;
  localparam int W     = LN * DW;
  localparam int CW    = (W > 32) ? W : 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] frame_beats;
  logic        err_clr;
  logic        range_err;

  fft_out_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();

  fft_out_stage #(
    .DATA_WIDTH (DW),
    .LANES      (LN),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .frame_beats (frame_beats),
    .err_clr     (err_clr),
    .range_err   (range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           avail;
  } exp_t;

  exp_t m_q[$];
  int   m_fpos;
  bit   m_err;
  int   cyc;
  int   n_tests;
  int   n_fail;
  bit   obs_acc, obs_rd, obs_last;

  int tp1_in  [LN] = '{0, 16, 17, 33, 5, 18, 20, 1};
  int tp1_out [LN] = '{0, 16, 0, 16, 5, 1, 3, 1};
  int tp3_out [LN] = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic chk_eq(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_lanes(input int v [LN]);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < LN; i++) r[i*DW +: DW] = DW'(v[i]);
    return r;
  endfunction

  // Beat-level reference: reduce each lane, then optionally reorder lanes.
  function automatic logic [W-1:0] ref_beat(input logic [W-1:0] din, input longint q,
                                            input bit red, input bit perm, output bit rng);
    longint       lane [LN];
    logic [W-1:0] r;
    int           src;
    rng = 1'b0;
    r   = '0;
    for (int i = 0; i < LN; i++) begin
      lane[i] = longint'(din[i*DW +: DW]);
      if (red && lane[i] >= 2 * q) rng = 1'b1;
      if (red && lane[i] >= q) lane[i] = lane[i] - q;
    end
    for (int i = 0; i < LN; i++) begin
      src = i;
      if (perm) begin
        src = 0;
        for (int b = 0; b < $clog2(LN); b++) src = src * 2 + ((i >> b) & 1);
      end
      r[i*DW +: DW] = DW'(lane[src]);
    end
    return r;
  endfunction

  function automatic int fb_eff();
    return (frame_beats == 16'd0) ? 1 : int'(frame_beats);
  endfunction

  // One clock: check outputs mid-cycle, advance the model, then move past the edge.
  task automatic step();
    bit           e_valid, e_last, acc, rd, rng;
    logic [W-1:0] e_data, nd;
    @(negedge clk);
    e_valid = (m_q.size() > 0) && (m_q[0].avail <= cyc);
    e_data  = e_valid ? m_q[0].data : '0;
    e_last  = e_valid && (m_fpos == fb_eff() - 1);
    chk_eq("in_ready", bus.in_ready, m_q.size() < DEPTH);
    chk_eq("out_valid", bus.out_valid, e_valid);
    chk_eq("out_last", bus.out_last, e_last);
    chk_eq("range_err", range_err, m_err);
    if (e_valid) chk_eq("out_data", bus.out_data, e_data);
    obs_acc  = bus.in_valid && bus.in_ready;
    obs_rd   = bus.out_valid && bus.out_ready;
    obs_last = bus.out_last;
    acc = bus.in_valid && (m_q.size() < DEPTH);
    rd  = e_valid && bus.out_ready;
    rng = 1'b0;
    if (rd) begin
      void'(m_q.pop_front());
      m_fpos = e_last ? 0 : m_fpos + 1;
    end
    if (acc) begin
      nd = ref_beat(bus.in_data, longint'(bus.modular), bus.reduce_en, bus.perm_en, rng);
      m_q.push_back('{nd, cyc + 3});
    end
    if (rng) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    err_clr      = 1'b0;
    rst_n        = 1'b1;
    #1;
    chk_eq("rst_in_ready", bus.in_ready, 0);
    chk_eq("rst_out_valid", bus.out_valid, 0);
    chk_eq("rst_out_data", bus.out_data, 0);
    chk_eq("rst_out_last", bus.out_last, 0);
    chk_eq("rst_range_err", range_err, 0);
    m_q.delete();
    m_fpos = 0;
    m_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  task automatic rand_beat(input bit rnd_ctl);
    int unsigned q, lim;
    q   = $urandom_range(0, 40000);
    lim = (3 * q > 65535) ? 65535 : 3 * q;
    bus.modular = DW'(q);
    for (int i = 0; i < LN; i++) bus.in_data[i*DW +: DW] = DW'($urandom_range(0, lim));
    bus.reduce_en = rnd_ctl ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.perm_en   = rnd_ctl ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic drain(input int n);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (n) step();
  endtask

  task automatic rand_phase(input int n);
    for (int c = 0; c < n; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      err_clr       = ($urandom_range(0, 15) == 0);
      rand_beat(1'b1);
      step();
    end
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, outs, stall_acc, first_c, last_c;
    int lasts[$];
    n_tests = 0; n_fail = 0; cyc = 0; m_fpos = 0; m_err = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.modular = DW'(17);
    bus.reduce_en = 1'b0; bus.perm_en = 1'b0; bus.out_ready = 1'b1;
    frame_beats = 16'd1; err_clr = 1'b0;
    do_reset();

    // Basic reduction, three-edge latency, single-beat frame.
    bus.in_data = pack_lanes(tp1_in); bus.modular = DW'(17);
    bus.reduce_en = 1'b1; bus.perm_en = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step();
    chk_eq("tp1_valid", bus.out_valid, 1);
    chk_eq("tp1_data", bus.out_data, pack_lanes(tp1_out));
    chk_eq("tp1_last", bus.out_last, 1);
    chk_eq("tp1_err", range_err, 0);
    drain(2);

    // Out-of-range lane, clear, and set-over-clear priority.
    bus.in_data = '0;
    for (int i = 0; i < LN; i++) bus.in_data[i*DW +: DW] = DW'(3);
    bus.in_data[DW-1:0] = DW'(40);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk_eq("tp2_err_set", range_err, 1);
    step(); step();
    chk_eq("tp2_lane0", bus.out_data[DW-1:0], 23);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk_eq("tp2_err_clr", range_err, 0);
    bus.in_valid = 1'b1; err_clr = 1'b1;
    step();
    bus.in_valid = 1'b0; err_clr = 1'b0;
    chk_eq("tp2_err_prio", range_err, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    drain(3);

    // Bit-reversed lane order.
    for (int i = 0; i < LN; i++) bus.in_data[i*DW +: DW] = DW'(i);
    bus.reduce_en = 1'b0; bus.perm_en = 1'b1; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step();
    chk_eq("tp3_perm", bus.out_data, pack_lanes(tp3_out));
    drain(2);

    // Back-pressure: 20 beats with the sink stalled for 10 cycles.
    sent = 0; outs = 0; stall_acc = 0;
    bus.in_valid = 1'b1; rand_beat(1'b1);
    for (int c = 0; c < 300 && (sent < 20 || m_q.size() > 0); c++) begin
      bus.out_ready = (c >= 10);
      if (sent >= 20) bus.in_valid = 1'b0;
      step();
      if (obs_rd) outs++;
      if (obs_acc) begin
        sent++;
        if (c < 10) stall_acc++;
        rand_beat(1'b1);
      end
    end
    chk_eq("stall_accepts", stall_acc, 4);
    chk_eq("stall_sent", sent, 20);
    chk_eq("stall_outs", outs, 20);

    // Frame marking and full throughput.
    frame_beats = 16'd4; bus.out_ready = 1'b1;
    sent = 0; outs = 0; first_c = -1; last_c = -1; lasts.delete();
    bus.in_valid = 1'b1; rand_beat(1'b1);
    for (int c = 0; c < 100 && (sent < 10 || m_q.size() > 0); c++) begin
      if (sent >= 10) bus.in_valid = 1'b0;
      step();
      if (obs_rd) begin
        if (obs_last) lasts.push_back(outs);
        if (first_c < 0) first_c = c;
        last_c = c;
        outs++;
      end
      if (obs_acc) begin sent++; rand_beat(1'b1); end
    end
    chk_eq("frame_outs", outs, 10);
    chk_eq("frame_nlast", lasts.size(), 2);
    chk_eq("frame_last0", (lasts.size() > 0) ? lasts[0] : -1, 3);
    chk_eq("frame_last1", (lasts.size() > 1) ? lasts[1] : -1, 7);
    chk_eq("throughput", last_c - first_c, 9);

    rand_phase(400);
    drain(12);

    // Reset with three beats in flight.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; rand_beat(1'b1); sent = 0;
    for (int c = 0; c < 20 && sent < 3; c++) begin
      step();
      if (obs_acc) begin sent++; rand_beat(1'b1); end
    end
    chk_eq("midrst_sent", sent, 3);
    do_reset();
    drain(6);
    frame_beats = 16'd4; sent = 0; outs = 0; lasts.delete();
    bus.in_valid = 1'b1; rand_beat(1'b1);
    for (int c = 0; c < 50 && (sent < 4 || m_q.size() > 0); c++) begin
      if (sent >= 4) bus.in_valid = 1'b0;
      step();
      if (obs_rd) begin
        if (obs_last) lasts.push_back(outs);
        outs++;
      end
      if (obs_acc) begin sent++; rand_beat(1'b1); end
    end
    chk_eq("postrst_outs", outs, 4);
    chk_eq("postrst_last", (lasts.size() > 0) ? lasts[0] : -1, 3);

    frame_beats = 16'd0;
    rand_phase(300);
    drain(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
